// File: rtl/bin_to_bcd_display_if.sv
// Conversion request/result bundle between a requester and bin_to_bcd_display.
// The master drives the request; the slave (converter) returns registered results.
interface bin_to_bcd_display_if #(
    parameter int unsigned NUM_BITS = 14
);
    logic                start;
    logic [NUM_BITS-1:0] bin_in;
    logic [3:0]          dp_in;
    logic [15:0]         word_out;
    logic [7:0]          display_mask_out;
    logic                busy;
    logic                done;
    logic                overflow;

    modport master (
        output start, bin_in, dp_in,
        input  word_out, display_mask_out, busy, done, overflow
    );

    modport slave (
        input  start, bin_in, dp_in,
        output word_out, display_mask_out, busy, done, overflow
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Iterative shift-and-add-3 binary-to-BCD converter with leading-zero blanking,
// feeding a 7-segment digit driver with a packed BCD word and digit/dp mask.
module bin_to_bcd_display #(
    parameter bit          BLANK_LEADING = 1'b1,
    parameter int unsigned NUM_BITS      = 14
) (
    input logic                  mclk,
    input logic                  rst,
    bin_to_bcd_display_if.slave  bus
);
    localparam int unsigned CntW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

    state_e              state_q;
    logic [NUM_BITS-1:0] bin_q;
    logic [15:0]         bcd_q;
    logic [3:0]          dp_q;
    logic                ovf_pending_q;
    logic [CntW-1:0]     cnt_q;

    logic [15:0]         word_q;
    logic [7:0]          mask_q;
    logic                busy_q;
    logic                done_q;
    logic                overflow_q;

    logic [15:0]         bcd_adj;
    logic [3:0]          digit_en;
    logic                thou_nz;
    logic                hund_nz;
    logic                tens_nz;
    logic                in_range_n;

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        thou_nz = |bcd_q[15:12];
        hund_nz = |bcd_q[11:8];
        tens_nz = |bcd_q[7:4];
        if (BLANK_LEADING) begin
            digit_en = {thou_nz, thou_nz | hund_nz, thou_nz | hund_nz | tens_nz, 1'b1};
        end else begin
            digit_en = 4'hF;
        end
    end

    assign in_range_n = 32'(bus.bin_in) > 32'd9999;

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q       <= StIdle;
            bin_q         <= '0;
            bcd_q         <= '0;
            dp_q          <= '0;
            ovf_pending_q <= 1'b0;
            cnt_q         <= '0;
            word_q        <= 16'h0000;
            mask_q        <= 8'h01;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        bin_q         <= bus.bin_in;
                        dp_q          <= bus.dp_in;
                        ovf_pending_q <= in_range_n;
                        bcd_q         <= '0;
                        cnt_q         <= CntW'(NUM_BITS);
                        busy_q        <= 1'b1;
                        state_q       <= StShift;
                    end
                end
                StShift: begin
                    bcd_q <= {bcd_adj[14:0], bin_q[NUM_BITS-1]};
                    bin_q <= {bin_q[NUM_BITS-2:0], 1'b0};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    // Out-of-range values saturate; the accumulator is meaningless then.
                    if (ovf_pending_q) begin
                        word_q <= 16'h9999;
                        mask_q <= {dp_q, 4'hF};
                    end else begin
                        word_q <= bcd_q;
                        mask_q <= {dp_q, digit_en};
                    end
                    overflow_q <= ovf_pending_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_out         = word_q;
    assign bus.display_mask_out = mask_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.overflow         = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display: a transaction-level decimal model checked
// every cycle against two instances (blanking on and off), plus literal directed checks.
module tb_bin_to_bcd_display;
    logic mclk;
    logic rst;
    logic chk_en;

    int n_checks;
    int n_err;

    bin_to_bcd_display_if #(.NUM_BITS(14)) bus ();
    bin_to_bcd_display_if #(.NUM_BITS(14)) bus0 ();

    assign bus0.start  = bus.start;
    assign bus0.bin_in = bus.bin_in;
    assign bus0.dp_in  = bus.dp_in;

    bin_to_bcd_display #(.BLANK_LEADING(1'b1), .NUM_BITS(14)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    bin_to_bcd_display #(.BLANK_LEADING(1'b0), .NUM_BITS(14)) dut0 (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus0)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a conversion accepted while idle produces its result 15 edges later.
    int          m_left;
    int          m_val;
    logic [3:0]  m_dp;
    logic [15:0] e_word;
    logic [7:0]  e_mask;
    logic [7:0]  e_mask0;
    logic        e_busy;
    logic        e_done;
    logic        e_ovf;

    always @(posedge mclk) begin
        if (rst) begin
            m_left  = 0;
            e_word  = 16'h0000;
            e_mask  = 8'h01;
            e_mask0 = 8'h01;
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_ovf   = 1'b0;
        end else begin
            e_done = 1'b0;
            if (m_left == 0) begin
                if (bus.start === 1'b1) begin
                    m_val  = int'(bus.bin_in);
                    m_dp   = bus.dp_in;
                    m_left = 15;
                    e_busy = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    e_busy = 1'b0;
                    e_done = 1'b1;
                    e_mask0 = {m_dp, 4'hF};
                    if (m_val > 9999) begin
                        e_word = 16'h9999;
                        e_mask = {m_dp, 4'hF};
                        e_ovf  = 1'b1;
                    end else begin
                        e_word[15:12] = 4'(m_val / 1000);
                        e_word[11:8]  = 4'((m_val / 100) % 10);
                        e_word[7:4]   = 4'((m_val / 10) % 10);
                        e_word[3:0]   = 4'(m_val % 10);
                        if (m_val >= 1000)     e_mask = {m_dp, 4'hF};
                        else if (m_val >= 100) e_mask = {m_dp, 4'h7};
                        else if (m_val >= 10)  e_mask = {m_dp, 4'h3};
                        else                   e_mask = {m_dp, 4'h1};
                        e_ovf = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge mclk) begin
        if (chk_en) begin
            check("word_out", bus.word_out, e_word);
            check("mask", 16'(bus.display_mask_out), 16'(e_mask));
            check("busy", 16'(bus.busy), 16'(e_busy));
            check("done", 16'(bus.done), 16'(e_done));
            check("overflow", 16'(bus.overflow), 16'(e_ovf));
            check("mask_noblank", 16'(bus0.display_mask_out), 16'(e_mask0));
            check("word_noblank", bus0.word_out, e_word);
        end
    end

    int done_seen;
    always @(posedge mclk) if (bus.done === 1'b1) done_seen++;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (bus.done === 1'b1) got = 1'b1;
        end
        check("done_timeout", 16'(got), 16'd1);
    endtask

    task automatic run_conv(input int val, input logic [3:0] dp, input logic [15:0] x_word,
                            input logic [7:0] x_mask, input logic [7:0] x_mask0,
                            input logic x_ovf);
        int busy_cycles;
        bus.start  = 1'b1;
        bus.bin_in = 14'(val);
        bus.dp_in  = dp;
        step();
        bus.start  = 1'b0;
        bus.bin_in = 14'($urandom_range(0, 16383));
        bus.dp_in  = 4'($urandom);
        busy_cycles = 0;
        for (int i = 0; i < 40 && bus.done !== 1'b1; i++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            step();
        end
        check("busy_len", 16'(busy_cycles), 16'd15);
        check("lit_done", 16'(bus.done), 16'd1);
        check("lit_word", bus.word_out, x_word);
        check("lit_mask", 16'(bus.display_mask_out), 16'(x_mask));
        check("lit_mask0", 16'(bus0.display_mask_out), 16'(x_mask0));
        check("lit_ovf", 16'(bus.overflow), 16'(x_ovf));
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        done_seen  = 0;
        chk_en     = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        bus.dp_in  = '0;
        step();
        step();
        chk_en = 1'b1;
        rst    = 1'b0;
        check("rst_word", bus.word_out, 16'h0000);
        check("rst_mask", 16'(bus.display_mask_out), 16'h0001);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_ovf", 16'(bus.overflow), 16'd0);

        run_conv(1234, 4'b0000, 16'h1234, 8'h0F, 8'h0F, 1'b0);
        step();
        check("done_single", 16'(bus.done), 16'd0);
        run_conv(7, 4'b0000, 16'h0007, 8'h01, 8'h0F, 1'b0);
        run_conv(0, 4'b0000, 16'h0000, 8'h01, 8'h0F, 1'b0);
        run_conv(9999, 4'b0000, 16'h9999, 8'h0F, 8'h0F, 1'b0);
        run_conv(305, 4'b0100, 16'h0305, 8'h47, 8'h4F, 1'b0);
        run_conv(10000, 4'b0000, 16'h9999, 8'h0F, 8'h0F, 1'b1);
        run_conv(42, 4'b0000, 16'h0042, 8'h03, 8'h0F, 1'b0);
        run_conv(16383, 4'b1010, 16'h9999, 8'hAF, 8'hAF, 1'b1);

        // Starts during SHIFT and FINISH are dropped; start in the done cycle is taken.
        step();
        bus.start  = 1'b1;
        bus.bin_in = 14'd1234;
        bus.dp_in  = 4'b0000;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start  = 1'b1;
        bus.bin_in = 14'd5678;
        step();
        bus.start = 1'b0;
        repeat (11) step();
        bus.start = 1'b1;
        step();
        check("ign_done", 16'(bus.done), 16'd1);
        check("ign_word", bus.word_out, 16'h1234);
        step();
        bus.start = 1'b0;
        check("acc_busy", 16'(bus.busy), 16'd1);
        wait_done();
        check("acc_word", bus.word_out, 16'h5678);
        check("acc_mask", 16'(bus.display_mask_out), 16'h000F);

        // Reset in the middle of a conversion aborts it.
        step();
        bus.start  = 1'b1;
        bus.bin_in = 14'd4321;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 16'(bus.busy), 16'd0);
        check("abort_done", 16'(bus.done), 16'd0);
        check("abort_word", bus.word_out, 16'h0000);
        check("abort_mask", 16'(bus.display_mask_out), 16'h0001);
        done_seen = 0;
        repeat (20) step();
        check("abort_no_done", 16'(done_seen), 16'd0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bus.bin_in = 14'($urandom_range(0, 99));
                1:       bus.bin_in = 14'($urandom_range(9990, 10010));
                default: bus.bin_in = 14'($urandom_range(0, 16383));
            endcase
            bus.dp_in = 4'($urandom);
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Sequential binary-to-BCD converter (iterative shift-and-add-3, "double dabble") with leading-zero blanking.
- Sits directly upstream of the 7-segment digit driver and produces its 16-bit packed BCD word and 8-bit display mask.
- Takes a 14-bit binary value (0..9999) plus decimal-point requests on a start strobe.
- Presents four BCD digits and mask as registered, held outputs, with a busy/done handshake.

Parameters:
BLANK_LEADING, 1, 1 = blank leading zero digits in mask[3:0]; 0 = mask[3:0] always 4'hF
NUM_BITS, 14, binary input width; iteration count equals NUM_BITS

Ports:
mclk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  conversion request, sampled only when busy=0
bin_in  input  14  binary value to convert, captured when start is accepted
dp_in  input  4  decimal-point enables per digit (bit0 = rightmost), captured with bin_in
word_out  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
display_mask_out  output  8  [3:0] digit enables (1 = lit), [7:4] decimal-point enables
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when word_out/display_mask_out update
overflow  output  1  set when the last accepted bin_in was greater than 9999

Behaviour:
- Single clock domain: mclk.
- rst is synchronous and active-high.
- Reset values: word_out=16'h0000, display_mask_out=8'h01, busy=0, done=0, overflow=0, FSM=IDLE.
- rst asserted mid-conversion aborts the conversion; all outputs return to reset values on that edge.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - busy=0.
  - On an edge with start=1: latch bin_in into a shift register, latch dp_in, clear the 16-bit BCD accumulator, load iteration counter=NUM_BITS, go to SHIFT.
  - busy goes high after that edge.
  - start=0: stay in IDLE.
- SHIFT:
  - One iteration per cycle. For each BCD nibble >= 5, add 3 (combinational, same cycle).
  - Then shift {bcd, bin} left by 1, MSB of bin into bcd[0].
  - Decrement the counter; after the 14th iteration go to FINISH.
- FINISH:
  - Register word_out, display_mask_out and overflow; done=1 for exactly this one output cycle.
  - busy=0 after this edge; go to IDLE.
- Latency: start sampled at edge k, done and new outputs visible after edge k+15, busy high after edges k..k+14.
- start while busy=1 (SHIFT or FINISH) is ignored and not queued.
- start high in the cycle where done=1 is accepted (FSM is IDLE); back-to-back throughput is one conversion per 16 cycles.
- Overflow (latched bin_in > 9999):
  - word_out=16'h9999 (saturate), mask[3:0]=4'hF, overflow=1.
  - overflow clears on the next in-range conversion.
- Leading-zero blanking (BLANK_LEADING=1):
  - mask[3] lit iff thousands != 0.
  - mask[2] lit iff thousands or hundreds != 0.
  - mask[1] lit iff any of thousands, hundreds, tens != 0.
  - mask[0] always 1, so value 0 shows "0".
- mask[7:4] = latched dp_in, regardless of blanking. A dp on a blanked digit is still driven.
- Outputs hold their last value between conversions. bin_in/dp_in changes after acceptance have no effect.
- No combinational path from any input to any output.

Test Plan:
- Reset, then bin_in=1234, dp_in=0, start one cycle -> busy high 15 cycles; done pulses exactly once at start+15; word_out=16'h1234, mask=8'h0F, overflow=0.
- bin_in=7 -> word_out=16'h0007, mask=8'h01; bin_in=0 -> word_out=16'h0000, mask=8'h01; bin_in=9999 -> 16'h9999, mask=8'h0F.
- bin_in=305, dp_in=4'b0100 -> word_out=16'h0305, mask=8'h47; rerun with BLANK_LEADING=0 -> mask=8'h4F.
- bin_in=10000 -> word_out=16'h9999, mask=8'h0F, overflow=1; then bin_in=42 -> 16'h0042, mask=8'h03, overflow=0.
- Start 1234, pulse start with bin_in=5678 at cycles 3 and 15 -> both ignored, result 16'h1234; start with 5678 during the done cycle -> accepted, 16'h5678 after 15 more cycles.
- Assert rst at cycle 8 of a 4321 conversion -> next edge: busy=0, done=0, word_out=16'h0000, mask=8'h01; no done pulse follows.
